// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the pipeline memory-bus slice: access sizes,
// arbiter FSM state encoding and port-owner encoding.
package cpu_bus_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant select between the fetch and load/store ports.
// Outputs are one-hot or zero.
module mem_arb_grant #(
    parameter int DATA_PRIO = 1
) (
    input  logic inst_req,
    input  logic data_req,
    input  logic last_owner_data,
    output logic grant_inst,
    output logic grant_data
);

    // Data wins outright in priority mode; on a tie in round-robin mode the
    // port that did not own the last transaction wins.
    always_comb begin
        grant_data = data_req & ((DATA_PRIO != 0) | ~inst_req | ~last_owner_data);
        grant_inst = inst_req & ~grant_data;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-into-one memory port arbiter: accepts one fetch or load/store request
// at a time, holds it on the downstream request/address handshake and routes
// the single response back to the issuing port.
module mem_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int DATA_PRIO = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [DW-1:0] inst_rdata,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] data_rdata,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    owner_t        owner_q;
    owner_t        last_owner_q;
    logic          lat_wr;
    logic [1:0]    lat_size;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;

    logic grant_inst;
    logic grant_data;
    logic accept_inst;
    logic accept_data;
    logic resp_fire;

    mem_arb_grant #(
        .DATA_PRIO(DATA_PRIO)
    ) u_grant (
        .inst_req        (inst_req),
        .data_req        (data_req),
        .last_owner_data (last_owner_q == OWN_DATA),
        .grant_inst      (grant_inst),
        .grant_data      (grant_data)
    );

    // Acceptance is only possible in IDLE; gated by resetn so no addr_ok leaks out while held in reset.
    always_comb begin
        accept_inst = resetn & (state_q == ST_IDLE) & grant_inst;
        accept_data = resetn & (state_q == ST_IDLE) & grant_data;
        resp_fire   = (state_q == ST_WAIT) & mem_data_ok;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, owner and last-owner tracking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q      <= OWN_INST;
            last_owner_q <= OWN_INST;
            lat_wr       <= 1'b0;
            lat_size     <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
        end else begin
            if (accept_data) begin
                owner_q   <= OWN_DATA;
                lat_wr    <= data_wr;
                lat_size  <= data_size;
                lat_addr  <= data_addr;
                lat_wdata <= data_wdata;
            end else if (accept_inst) begin
                owner_q   <= OWN_INST;
                lat_wr    <= 1'b0;
                lat_size  <= SIZE_WORD;
                lat_addr  <= inst_addr;
                lat_wdata <= '0;
            end
            if (resp_fire) begin
                last_owner_q <= owner_q;
            end
        end
    end

    // Next-state logic; responses outside WAIT are ignored, including one
    // coinciding with mem_addr_ok.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept_inst | accept_data) state_d = ST_ADDR;
            ST_ADDR: if (mem_addr_ok)               state_d = ST_WAIT;
            ST_WAIT: if (mem_data_ok)               state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs and response routing to the owning port.
    always_comb begin
        inst_addr_ok = accept_inst;
        data_addr_ok = accept_data;
        mem_req      = (state_q == ST_ADDR);
        mem_wr       = lat_wr;
        mem_size     = lat_size;
        mem_addr     = lat_addr;
        mem_wdata    = lat_wdata;
        inst_data_ok = resp_fire & (owner_q == OWN_INST);
        data_data_ok = resp_fire & (owner_q == OWN_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance with data priority,
// one with round-robin ties; sel chooses which instance sees the stimulus.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } resp_exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sel;
    logic        inst_req, data_req, data_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  data_size;
    logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;

    logic        p1_inst_addr_ok, p1_inst_data_ok, p1_data_addr_ok, p1_data_data_ok;
    logic        p1_mem_req, p1_mem_wr;
    logic [1:0]  p1_mem_size;
    logic [31:0] p1_inst_rdata, p1_data_rdata, p1_mem_addr, p1_mem_wdata;
    logic        p0_inst_addr_ok, p0_inst_data_ok, p0_data_addr_ok, p0_data_data_ok;
    logic        p0_mem_req, p0_mem_wr;
    logic [1:0]  p0_mem_size;
    logic [31:0] p0_inst_rdata, p0_data_rdata, p0_mem_addr, p0_mem_wdata;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic      grant_q[$];
    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .DATA_PRIO(1)) u_prio (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req & sel), .inst_addr(inst_addr),
        .inst_addr_ok(p1_inst_addr_ok), .inst_data_ok(p1_inst_data_ok), .inst_rdata(p1_inst_rdata),
        .data_req(data_req & sel), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(p1_data_addr_ok), .data_data_ok(p1_data_data_ok), .data_rdata(p1_data_rdata),
        .mem_req(p1_mem_req), .mem_wr(p1_mem_wr), .mem_size(p1_mem_size),
        .mem_addr(p1_mem_addr), .mem_wdata(p1_mem_wdata),
        .mem_addr_ok(mem_addr_ok & sel), .mem_data_ok(mem_data_ok & sel), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .DATA_PRIO(0)) u_rr (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req & ~sel), .inst_addr(inst_addr),
        .inst_addr_ok(p0_inst_addr_ok), .inst_data_ok(p0_inst_data_ok), .inst_rdata(p0_inst_rdata),
        .data_req(data_req & ~sel), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(p0_data_addr_ok), .data_data_ok(p0_data_data_ok), .data_rdata(p0_data_rdata),
        .mem_req(p0_mem_req), .mem_wr(p0_mem_wr), .mem_size(p0_mem_size),
        .mem_addr(p0_mem_addr), .mem_wdata(p0_mem_wdata),
        .mem_addr_ok(mem_addr_ok & ~sel), .mem_data_ok(mem_data_ok & ~sel), .mem_rdata(mem_rdata)
    );

    assign inst_addr_ok = sel ? p1_inst_addr_ok : p0_inst_addr_ok;
    assign inst_data_ok = sel ? p1_inst_data_ok : p0_inst_data_ok;
    assign inst_rdata   = sel ? p1_inst_rdata   : p0_inst_rdata;
    assign data_addr_ok = sel ? p1_data_addr_ok : p0_data_addr_ok;
    assign data_data_ok = sel ? p1_data_data_ok : p0_data_data_ok;
    assign data_rdata   = sel ? p1_data_rdata   : p0_data_rdata;
    assign mem_req      = sel ? p1_mem_req      : p0_mem_req;
    assign mem_wr       = sel ? p1_mem_wr       : p0_mem_wr;
    assign mem_size     = sel ? p1_mem_size     : p0_mem_size;
    assign mem_addr     = sel ? p1_mem_addr     : p0_mem_addr;
    assign mem_wdata    = sel ? p1_mem_wdata    : p0_mem_wdata;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event expected none (t=%0t)", name, $time);
    endtask

    // Monitor: pop expectations whenever the selected DUT presents a handshake.
    always @(negedge clk) begin
        if (resetn) begin
            if (inst_addr_ok || data_addr_ok) begin
                if (grant_q.size() == 0) fail_event("addr_ok_unexpected");
                else chk("grant_port", {78'd0, inst_addr_ok, data_addr_ok},
                         grant_q.pop_front() ? 80'b01 : 80'b10);
            end
            if (mem_req && mem_addr_ok) begin
                if (mem_q.size() == 0) fail_event("mem_req_unexpected");
                else chk("mem_fields", {13'd0, mem_wr, mem_size, mem_addr, mem_wdata},
                         {13'd0, mem_q.pop_front()});
            end
            if (inst_data_ok || data_data_ok) begin
                if (resp_q.size() == 0) fail_event("data_ok_unexpected");
                else begin
                    resp_exp_t r;
                    r = resp_q.pop_front();
                    chk("resp_port", {78'd0, inst_data_ok, data_data_ok}, r.is_data ? 80'b01 : 80'b10);
                    chk("resp_rdata", {48'd0, r.is_data ? data_rdata : inst_rdata}, {48'd0, r.rdata});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        chk({name, "_ctl"}, {73'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                             mem_req, mem_wr, mem_size[0] | mem_size[1]}, 80'd0);
        chk({name, "_addr"}, {48'd0, mem_addr}, 80'd0);
        chk({name, "_wdata"}, {48'd0, mem_wdata}, 80'd0);
    endtask

    // Runs one transaction from its accept cycle: aw cycles of withheld
    // mem_addr_ok, dw idle WAIT cycles, then the response. drop: 1 inst, 2 data, 3 both.
    task automatic do_txn(input int aw, input int dw, input logic [31:0] rd,
                          input int drop, input logic [31:0] exp_addr);
        tick();
        if (drop[0]) inst_req = 1'b0;
        if (drop[1]) data_req = 1'b0;
        for (int i = 0; i < aw; i++) begin
            @(negedge clk);
            chk("bp_mem_req", {79'd0, mem_req}, 80'd1);
            chk("bp_mem_addr", {48'd0, mem_addr}, {48'd0, exp_addr});
            tick();
        end
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        for (int i = 0; i < dw; i++) tick();
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        tick();
        mem_data_ok = 1'b0;
    endtask

    task automatic push_inst(input logic [31:0] addr, input logic [31:0] rd);
        grant_q.push_back(1'b0);
        mem_q.push_back('{wr: 1'b0, size: 2'd2, addr: addr, wdata: 32'd0});
        resp_q.push_back('{is_data: 1'b0, rdata: rd});
    endtask

    task automatic push_data(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd);
        grant_q.push_back(1'b1);
        mem_q.push_back('{wr: wr, size: sz, addr: addr, wdata: wd});
        resp_q.push_back('{is_data: 1'b1, rdata: rd});
    endtask

    task automatic set_data(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd);
        data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = addr; data_wdata = wd;
    endtask

    initial begin
        resetn = 1'b0; sel = 1'b1;
        inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        inst_addr = '0; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

        // Reset state, priority instance
        tick();
        check_reset_outputs("reset_prio");
        tick();
        resetn = 1'b1;
        tick();

        // Single fetch
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        push_inst(32'hBFC0_0000, 32'h2401_0001);
        do_txn(0, 1, 32'h2401_0001, 1, 32'hBFC0_0000);
        tick();

        // Tie with data priority: store wins, fetch granted after data_ok
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        set_data(1'b1, 2'd0, 32'h0000_1000, 32'hDEAD_BEEF);
        push_data(1'b1, 2'd0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0000);
        do_txn(0, 0, 32'h0000_0000, 2, 32'h0000_1000);
        push_inst(32'hBFC0_0004, 32'h1111_2222);
        do_txn(0, 0, 32'h1111_2222, 1, 32'hBFC0_0004);
        tick();

        // Backpressure: 5 cycles without mem_addr_ok while a fetch is waiting
        set_data(1'b0, 2'd2, 32'h0000_2000, 32'h0);
        push_data(1'b0, 2'd2, 32'h0000_2000, 32'h0, 32'h3333_4444);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
        do_txn(5, 2, 32'h3333_4444, 2, 32'h0000_2000);
        push_inst(32'hBFC0_0008, 32'h5555_6666);
        do_txn(0, 1, 32'h5555_6666, 1, 32'hBFC0_0008);
        tick();

        // Stray response in IDLE
        mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("stray_ignored", {78'd0, inst_data_ok, data_data_ok}, 80'd0);
        tick();
        mem_data_ok = 1'b0;

        // Response in the mem_addr_ok cycle is ignored; the next one completes
        set_data(1'b0, 2'd1, 32'h0000_3000, 32'h0);
        push_data(1'b0, 2'd1, 32'h0000_3000, 32'h0, 32'h600D_F00D);
        tick();
        data_req = 1'b0;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("early_resp_ignored", {78'd0, inst_data_ok, data_data_ok}, 80'd0);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        tick();
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h600D_F00D;
        tick();
        mem_data_ok = 1'b0;
        tick();

        // Reset while in WAIT, then a stale response
        inst_req = 1'b1; inst_addr = 32'h0000_4000;
        grant_q.push_back(1'b0);
        mem_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h0000_4000, wdata: 32'd0});
        tick();
        inst_req = 1'b0;
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        tick();
        resetn = 1'b0;
        check_reset_outputs("reset_in_wait");
        tick();
        resetn = 1'b1;
        mem_data_ok = 1'b1; mem_rdata = 32'h7777_8888;
        @(negedge clk);
        chk("stale_resp_ignored", {78'd0, inst_data_ok, data_data_ok}, 80'd0);
        chk("post_reset_mem", {45'd0, mem_req, mem_wr, mem_size, mem_addr}, 80'd0);
        tick();
        mem_data_ok = 1'b0;
        tick();

        // Round-robin instance: reset, then both ports held for 4 transactions
        resetn = 1'b0; sel = 1'b0;
        check_reset_outputs("reset_rr");
        tick();
        resetn = 1'b1;
        tick();
        inst_req = 1'b1; inst_addr = 32'h0000_5000;
        set_data(1'b1, 2'd1, 32'h0000_6000, 32'hCAFE_F00D);
        push_data(1'b1, 2'd1, 32'h0000_6000, 32'hCAFE_F00D, 32'hA000_0001);
        do_txn(0, 0, 32'hA000_0001, 0, 32'h0000_6000);
        push_inst(32'h0000_5000, 32'hA000_0002);
        do_txn(0, 1, 32'hA000_0002, 0, 32'h0000_5000);
        push_data(1'b1, 2'd1, 32'h0000_6000, 32'hCAFE_F00D, 32'hA000_0003);
        do_txn(1, 0, 32'hA000_0003, 0, 32'h0000_6000);
        push_inst(32'h0000_5000, 32'hA000_0004);
        do_txn(0, 2, 32'hA000_0004, 3, 32'h0000_5000);
        tick();
        tick();

        chk("grant_q_drained", {48'd0, grant_q.size()}, 80'd0);
        chk("mem_q_drained", {48'd0, mem_q.size()}, 80'd0);
        chk("resp_q_drained", {48'd0, resp_q.size()}, 80'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-into-one arbiter and sequencer that lets the pipeline's instruction-fetch port and data-memory port share a single memory bus. It sits between the pipeline's inst/data request interfaces and the single downstream memory port used by the bus bridge. It accepts one request at a time, forwards it with a held request/address handshake, and routes the single response back to whichever port issued it. It keeps at most one transaction outstanding and never reorders.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- DATA_PRIO, 1, 1 = data port always wins ties; 0 = round-robin on ties

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low
- inst_req  in  1  fetch request (read only)
- inst_addr  in  AW  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid (1-cycle pulse)
- inst_rdata  out  DW  fetch data
- data_req  in  1  load/store request
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  AW  load/store address
- data_wdata  in  DW  store data
- data_addr_ok  out  1  load/store request accepted this cycle
- data_data_ok  out  1  load data valid / store done (1-cycle pulse)
- data_rdata  out  DW  load data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write
- mem_size  out  2  downstream size
- mem_addr  out  AW  downstream address
- mem_wdata  out  DW  downstream store data
- mem_addr_ok  in  1  downstream accepted the request
- mem_data_ok  in  1  downstream response
- mem_rdata  in  DW  downstream read data

## Operation
- FSM states: IDLE, ADDR, WAIT. Owner register (INST or DATA) and last-owner register (used in round-robin mode).
- IDLE, grant selection:
  - Grant data_req if DATA_PRIO = 1.
  - If DATA_PRIO = 0 and both ports request, grant the port that is not last-owner.
  - Otherwise grant whichever port is requesting.
- IDLE, on a grant:
  - The granted port's addr_ok is high combinationally in the same cycle.
  - Latch wr, size, addr, wdata. Inst requests latch wr = 0, size = 2.
  - Set owner; go to ADDR.
  - The losing port's addr_ok stays 0.
- ADDR: mem_req = 1 with the latched fields held stable. On mem_addr_ok go to WAIT.
- WAIT: mem_req = 0.
  - On mem_data_ok, raise owner's data_ok for that cycle and pass mem_rdata through combinationally to owner's rdata.
  - Update last-owner; return to IDLE.
- inst_rdata and data_rdata both always carry mem_rdata. Only the owner's data_ok qualifies it.
- mem_data_ok outside WAIT is ignored. This includes a response arriving in the same cycle as mem_addr_ok.
- No new request is accepted until the return to IDLE. The earliest is the cycle after data_ok.

## Timing
- Reset:
  - state = IDLE, owner = INST, last-owner = INST, latched fields = 0.
  - mem_req = 0 and all addr_ok / data_ok = 0.
  - mem_wr, mem_size, mem_addr, mem_wdata = 0.
- Minimum transaction length is 3 cycles:
  - cycle 0: addr_ok (IDLE)
  - cycle 1: mem_req with mem_addr_ok (ADDR)
  - cycle 2: mem_data_ok, then requester data_ok (WAIT)
  - cycle 3: next accept possible
- mem_req, once high, holds with unchanged fields until mem_addr_ok.
- A request still held by the losing port is granted in the next IDLE cycle.
- Reset asserted mid-transaction: return to IDLE immediately and drop mem_req. A stale mem_data_ok arriving later is ignored.

## Structure
- Shared package cpu_bus_pkg holds:
  - SIZE_BYTE / SIZE_HALF / SIZE_WORD constants
  - FSM state encoding
  - owner encoding
- Sub-module mem_arb_grant: combinational grant select from inst_req, data_req, last-owner and DATA_PRIO. Outputs grant_inst and grant_data, which are one-hot or zero.
- Top holds the FSM, the latch registers and response routing.

## Test plan
- Single fetch: inst_req with addr 0xBFC00000; slave gives addr_ok in cycle 1 and data_ok in cycle 3 with rdata 0x24010001 -> mem_addr = 0xBFC00000, mem_wr = 0, mem_size = 2, one inst_data_ok pulse with inst_rdata = 0x24010001, data_data_ok stays 0.
- Tie with DATA_PRIO = 1: both req in the same cycle, data is a store to 0x1000 with wdata 0xDEADBEEF, size 0 -> data_addr_ok first and mem_wr = 1, size 0; inst granted only after data_data_ok.
- Tie with DATA_PRIO = 0: both req held over 4 transactions -> owners alternate DATA, INST, DATA, INST (last-owner INST after reset, so DATA goes first).
- Backpressure: slave withholds mem_addr_ok for 5 cycles -> mem_req and mem_addr stable for all 5 cycles, no second addr_ok to either port.
- Stray and early responses: mem_data_ok in IDLE, and mem_data_ok in the mem_addr_ok cycle -> both ignored, FSM waits for the next mem_data_ok.
- Reset in WAIT: resetn low for 1 cycle, then the slave's mem_data_ok arrives -> no data_ok on either port, all outputs at reset values.
